// File: rtl/mc_cpu_core_if.sv
// Unified memory port of mc_cpu_core.
// Handshake: the core raises mem_req_o with mem_we_o/mem_addr_o/mem_wdata_o
// and holds all four stable until a cycle in which mem_ack_i is also high;
// that cycle completes the transfer, and for a read mem_rdata_i is valid in
// that same cycle. mem_ack_i may be a combinational function of mem_req_o.
interface mc_cpu_core_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core with one shared memory port.
// Sequence: IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// Supports add/sub/and/or/slt, addi, lw, sw, beq, j; anything else halts.
// Optional feature macro MC_CPU_MUL_EN: adds R-type mul (funct 0x18) using a
// 32-step shift-add unit; when undefined, funct 0x18 is illegal.
module mc_cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREG     = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  mc_cpu_core_if.master mem,
  output logic [31:0]   pc_o,
  output logic          retire_o,
  output logic          halted_o,
  output logic [2:0]    dbg_state
);

  localparam int RW = $clog2(NREG);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
`ifdef MC_CPU_MUL_EN
  localparam logic [5:0] F_MUL = 6'h18;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [31:0] pc_q;     // address of the instruction in flight
  logic [31:0] pc4_q;    // pc_q + 4, captured at fetch
  logic [31:0] ir_q;
  logic [31:0] a_q, b_q, imm_q;
  logic [31:0] ea_q;     // load/store byte address
  logic [31:0] res_q;    // value headed for the register file
  logic [RW-1:0] dst_q;
  logic [31:0] rf [NREG];

  // Instruction fields
  logic [5:0]    op, funct;
  logic [RW-1:0] rs, rt, rd;
  assign op    = ir_q[31:26];
  assign funct = ir_q[5:0];
  assign rs    = ir_q[21 +: RW];
  assign rt    = ir_q[16 +: RW];
  assign rd    = ir_q[11 +: RW];

  logic xfer;
  assign xfer = mem.mem_req_o & mem.mem_ack_i;

  // Multiplier status; in the default build mul never exists
  logic        is_mul;
  logic        mul_done;
  logic [31:0] mul_acc;

`ifdef MC_CPU_MUL_EN
  logic [31:0] mul_mcand_q, mul_mplier_q, mul_acc_q;
  logic [5:0]  mul_cnt_q;

  assign is_mul   = (op == OP_R) && (funct == F_MUL);
  assign mul_done = (mul_cnt_q == 6'd32);
  assign mul_acc  = mul_acc_q;

  // Shift-add multiplier: loaded in DECODE, one partial product per EXEC cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_acc_q    <= '0;
      mul_cnt_q    <= '0;
    end else if (state_q == S_DECODE) begin
      mul_mcand_q  <= rf[rs];
      mul_mplier_q <= rf[rt];
      mul_acc_q    <= '0;
      mul_cnt_q    <= '0;
    end else if (state_q == S_EXEC && is_mul && !mul_done) begin
      if (mul_mplier_q[0]) mul_acc_q <= mul_acc_q + mul_mcand_q;
      mul_mcand_q  <= mul_mcand_q << 1;
      mul_mplier_q <= mul_mplier_q >> 1;
      mul_cnt_q    <= mul_cnt_q + 6'd1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b1;
  assign mul_acc  = '0;
`endif

  // ALU, effective address and branch/jump targets
  logic        alu_ok;
  logic [31:0] alu_res, ea, br_target, j_target, next_pc;
  logic        misaligned;
  always_comb begin
    alu_ok  = 1'b1;
    alu_res = '0;
    case (funct)
      F_ADD:   alu_res = a_q + b_q;
      F_SUB:   alu_res = a_q - b_q;
      F_AND:   alu_res = a_q & b_q;
      F_OR:    alu_res = a_q | b_q;
      F_SLT:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
`ifdef MC_CPU_MUL_EN
      F_MUL:   alu_res = mul_acc;
`endif
      default: alu_ok = 1'b0;
    endcase
    ea         = a_q + imm_q;
    misaligned = (ea[1:0] != 2'b00);
    br_target  = pc4_q + {imm_q[29:0], 2'b00};
    j_target   = {pc4_q[31:28], ir_q[25:0], 2'b00};
    next_pc    = pc4_q;
    if (state_q == S_EXEC && op == OP_BEQ && a_q == b_q) next_pc = br_target;
    if (state_q == S_EXEC && op == OP_J) next_pc = j_target;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and bus/retire outputs, all decoded from the current state
  logic        req, we, retire;
  logic [31:0] addr, wdata;
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        req  = 1'b1;
        addr = pc_q;
        if (mem.mem_ack_i) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_R: begin
            if (!alu_ok)                state_d = S_HALT;
            else if (is_mul && !mul_done) state_d = S_EXEC;
            else                        state_d = S_WB;
          end
          OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW: state_d = misaligned ? S_HALT : S_MEM;
          OP_BEQ, OP_J: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        req   = 1'b1;
        we    = (op == OP_SW);
        addr  = ea_q;
        wdata = (op == OP_SW) ? b_q : '0;
        if (mem.mem_ack_i) begin
          if (op == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers and register file
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q  <= RESET_PC;
      pc4_q <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      ea_q  <= '0;
      res_q <= '0;
      dst_q <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (xfer) begin
          ir_q  <= mem.mem_rdata_i;
          pc4_q <= pc_q + 32'd4;
        end
        S_DECODE: begin
          a_q   <= rf[rs];
          b_q   <= rf[rt];
          imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
        end
        S_EXEC: begin
          ea_q  <= ea;
          res_q <= (op == OP_ADDI) ? (a_q + imm_q) : alu_res;
          dst_q <= (op == OP_R) ? rd : rt;
        end
        S_MEM: if (xfer) res_q <= mem.mem_rdata_i;
        S_WB: if (dst_q != '0) rf[dst_q] <= res_q;
        default: ;
      endcase
      if (retire) pc_q <= next_pc;
    end
  end

  assign mem.mem_req_o   = req;
  assign mem.mem_we_o    = we;
  assign mem.mem_addr_o  = addr;
  assign mem.mem_wdata_o = wdata;
  assign retire_o        = retire;
  assign pc_o            = pc_q;
  assign halted_o        = (state_q == S_HALT);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: unified memory with configurable wait states,
// an instruction-level reference model, a per-cycle compare process and
// directed programs with literal expectations.
module tb_mc_cpu_core;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_o;
  logic        retire_o, halted_o;
  logic [2:0]  dbg_state;

  mc_cpu_core_if bus();

  mc_cpu_core dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .mem       (bus),
    .pc_o      (pc_o),
    .retire_o  (retire_o),
    .halted_o  (halted_o),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory with wait states ----------------
  logic [31:0] ram [256];
  int          nwait = 0;
  int          wcnt  = 0;

  assign bus.mem_ack_i   = bus.mem_req_o && (wcnt == nwait);
  assign bus.mem_rdata_i = ram[bus.mem_addr_o[9:2]];

  always @(posedge clk) begin
    if (!rst_i)                              wcnt <= 0;
    else if (bus.mem_req_o && bus.mem_ack_i) wcnt <= 0;
    else if (bus.mem_req_o)                  wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (bus.mem_req_o && bus.mem_ack_i && bus.mem_we_o)
      ram[bus.mem_addr_o[9:2]] = bus.mem_wdata_o;
  end

  // ---------------- scoring ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  logic [31:0] m_mem  [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] cur_pc;
  int          exp_ret_lat, exp_halt_lat;
  logic [31:0] exp_addr_q [$];
  logic        exp_we_q   [$];
  logic [31:0] exp_q      [$];   // expected store data
  logic [31:0] fetch_log  [$];
  int          lat_log    [$];

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endtask

  task automatic push_xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_we_q.push_back(w);
    exp_q.push_back(d);
  endtask

  // Execute the instruction at m_pc and record what the bus and timing must show
  task automatic plan();
    logic [31:0] ins, a, b, sx, ea, nx;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    int          nxf, lat;
    logic        halt;
    ins = m_mem[m_pc[9:2]];
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    a  = m_regs[rs]; b = m_regs[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    cur_pc = m_pc;
    nx   = m_pc + 32'd4;
    push_xfer(m_pc, 1'b0, 32'd0);
    nxf  = 1;
    lat  = 0;
    halt = 1'b0;
    case (op)
      6'h00: begin
        lat = 4;
        case (fn)
          6'h20: wr(rd, a + b);
          6'h22: wr(rd, a - b);
          6'h24: wr(rd, a & b);
          6'h25: wr(rd, a | b);
          6'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
`ifdef MC_CPU_MUL_EN
          6'h18: begin wr(rd, a * b); lat = 36; end
`endif
          default: halt = 1'b1;
        endcase
      end
      6'h08: begin lat = 4; wr(rt, a + sx); end
      6'h23: begin
        ea = a + sx;
        if (ea[1:0] != 2'b00) halt = 1'b1;
        else begin
          push_xfer(ea, 1'b0, 32'd0);
          nxf = 2; lat = 5;
          wr(rt, m_mem[ea[9:2]]);
        end
      end
      6'h2B: begin
        ea = a + sx;
        if (ea[1:0] != 2'b00) halt = 1'b1;
        else begin
          push_xfer(ea, 1'b1, b);
          nxf = 2; lat = 4;
          m_mem[ea[9:2]] = b;
        end
      end
      6'h04: begin lat = 3; if (a == b) nx = m_pc + 32'd4 + (sx << 2); end
      6'h02: begin lat = 3; nx = {nx[31:28], ins[25:0], 2'b00}; end
      default: halt = 1'b1;
    endcase
    if (halt) begin
      exp_ret_lat  = 0;
      exp_halt_lat = 4 + nwait;
    end else begin
      exp_ret_lat  = lat + nwait * nxf;
      exp_halt_lat = 0;
    end
    m_pc = nx;
  endtask

  // ---------------- compare process ----------------
  logic        run_on = 1'b0;
  logic        need_plan = 1'b0;
  logic        halt_seen = 1'b0;
  logic        in_xfer = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;
  int          cyc = 0;
  int          xfer_n = 0;

  always @(posedge clk) begin
    if (!rst_i)       run_on <= 1'b0;
    else if (start_i) run_on <= 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      in_xfer = 1'b0;
    end else if (run_on) begin
      if (need_plan) begin
        plan();
        need_plan = 1'b0;
        cyc = 0;
        xfer_n = 0;
      end
      cyc++;
      if (halted_o) begin
        chk("req_in_halt", {31'd0, bus.mem_req_o}, 32'd0);
        chk("retire_in_halt", {31'd0, retire_o}, 32'd0);
        if (!halt_seen) begin
          halt_seen = 1'b1;
          chk("halt_latency", cyc, exp_halt_lat);
          chk("halt_xfers_left", exp_addr_q.size(), 0);
        end
      end
      if (bus.mem_req_o) begin
        if (in_xfer) begin
          chk("hold_addr", bus.mem_addr_o, h_addr);
          chk("hold_we", {31'd0, bus.mem_we_o}, {31'd0, h_we});
          chk("hold_wdata", bus.mem_wdata_o, h_wdata);
        end else begin
          in_xfer = 1'b1;
          h_addr  = bus.mem_addr_o;
          h_we    = bus.mem_we_o;
          h_wdata = bus.mem_wdata_o;
        end
        if (bus.mem_ack_i) begin
          if (exp_addr_q.size() == 0) begin
            chk("xfer_extra", bus.mem_addr_o, 32'hFFFF_FFFF);
          end else begin
            logic [31:0] ea, ed;
            logic        ew;
            ea = exp_addr_q.pop_front();
            ew = exp_we_q.pop_front();
            ed = exp_q.pop_front();
            chk("xfer_addr", bus.mem_addr_o, ea);
            chk("xfer_we", {31'd0, bus.mem_we_o}, {31'd0, ew});
            if (ew) chk("xfer_wdata", bus.mem_wdata_o, ed);
          end
          if (xfer_n == 0) fetch_log.push_back(bus.mem_addr_o);
          xfer_n++;
          in_xfer = 1'b0;
        end
      end
      if (retire_o) begin
        chk("retire_latency", cyc, exp_ret_lat);
        chk("retire_pc", pc_o, cur_pc);
        lat_log.push_back(cyc);
        need_plan = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      ram[i]   = 32'd0;
      m_mem[i] = 32'd0;
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    ram[a[9:2]]   = w;
    m_mem[a[9:2]] = w;
  endtask

  task automatic start_prog(input int waits);
    nwait = waits;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 32'h0000_0000;
    exp_addr_q.delete(); exp_we_q.delete(); exp_q.delete();
    fetch_log.delete(); lat_log.delete();
    halt_seen = 1'b0;
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_o, 32'h0000_0000);
    chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'd0);
    chk("rst_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_retire", {31'd0, retire_o}, 32'd0);
    chk("rst_halted", {31'd0, halted_o}, 32'd0);
    need_plan = 1'b1;
    rst_i = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_halt(input int limit);
    for (int n = 0; n < limit && !halted_o; n++) @(negedge clk);
    chk("halt_reached", {31'd0, halted_o}, 32'd1);
    repeat (5) @(negedge clk);
    for (int i = 1; i < 8; i++) chk($sformatf("reg%0d", i), dut.rf[i], m_regs[i]);
  endtask

  // ---------------- directed programs ----------------
  initial begin
    rst_i   = 1'b0;
    start_i = 1'b0;

    // Program A: addi pair, R-type suite, write to $0, illegal opcode
    clear_mem();
    put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    put(32'h08, enc_r(6'h20, 5'd1, 5'd2, 5'd3));
    put(32'h0C, enc_i(6'h2B, 5'd0, 5'd3, 16'h0080));
    put(32'h10, enc_r(6'h22, 5'd1, 5'd2, 5'd3));
    put(32'h14, enc_i(6'h2B, 5'd0, 5'd3, 16'h0084));
    put(32'h18, enc_r(6'h24, 5'd1, 5'd2, 5'd3));
    put(32'h1C, enc_i(6'h2B, 5'd0, 5'd3, 16'h0088));
    put(32'h20, enc_r(6'h25, 5'd1, 5'd2, 5'd3));
    put(32'h24, enc_i(6'h2B, 5'd0, 5'd3, 16'h008C));
    put(32'h28, enc_r(6'h2A, 5'd2, 5'd1, 5'd3));
    put(32'h2C, enc_i(6'h2B, 5'd0, 5'd3, 16'h0090));
    put(32'h30, enc_r(6'h2A, 5'd1, 5'd2, 5'd3));
    put(32'h34, enc_i(6'h2B, 5'd0, 5'd3, 16'h0094));
    put(32'h38, enc_r(6'h20, 5'd1, 5'd1, 5'd0));
    put(32'h3C, enc_i(6'h2B, 5'd0, 5'd0, 16'h0098));
    put(32'h40, 32'hFC00_0000);
    put(32'h98, 32'hDEAD_BEEF);
    start_prog(0);
    wait_halt(500);
    chk("A_r1", dut.rf[1], 32'd5);
    chk("A_r2", dut.rf[2], 32'hFFFF_FFFD);
    chk("A_add", ram[32], 32'd2);
    chk("A_sub", ram[33], 32'd8);
    chk("A_and", ram[34], 32'd5);
    chk("A_or", ram[35], 32'hFFFF_FFFD);
    chk("A_slt_t", ram[36], 32'd1);
    chk("A_slt_f", ram[37], 32'd0);
    chk("A_r0", ram[38], 32'd0);
    chk("A_first_fetch", fetch_log.size() > 0 ? fetch_log[0] : 32'hFFFF_FFFF, 32'd0);
    chk("A_addi_lat", lat_log.size() > 1 ? lat_log[1] : 0, 4);
    chk("A_sw_lat", lat_log.size() > 3 ? lat_log[3] : 0, 4);
    chk("A_retires", lat_log.size(), 16);

    // Program B: sw then lw through a memory with 3 wait states
    clear_mem();
    put(32'h00, enc_j(32'h40));
    put(32'h40, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h44, enc_i(6'h2B, 5'd0, 5'd1, 16'd8));
    put(32'h48, enc_i(6'h23, 5'd0, 5'd4, 16'd8));
    put(32'h4C, 32'hFC00_0000);
    start_prog(3);
    wait_halt(500);
    chk("B_mem8", ram[2], 32'd5);
    chk("B_r4", dut.rf[4], 32'd5);
    chk("B_j_lat", lat_log.size() > 0 ? lat_log[0] : 0, 6);
    chk("B_sw_lat", lat_log.size() > 2 ? lat_log[2] : 0, 10);
    chk("B_lw_lat", lat_log.size() > 3 ? lat_log[3] : 0, 11);

    // Program C: beq not taken, j, beq taken backwards, misaligned lw
    clear_mem();
    put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd1));
    put(32'h04, enc_i(6'h04, 5'd1, 5'd0, 16'd5));
    put(32'h08, enc_j(32'h40));
    put(32'h40, enc_i(6'h08, 5'd2, 5'd2, 16'd1));
    put(32'h44, enc_i(6'h04, 5'd2, 5'd1, 16'hFFFE));
    put(32'h48, enc_i(6'h23, 5'd0, 5'd5, 16'd6));
    start_prog(0);
    wait_halt(500);
    begin
      logic [31:0] want [8];
      want = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h44, 32'h40, 32'h44, 32'h48};
      chk("C_fetches", fetch_log.size(), 8);
      for (int i = 0; i < 8; i++)
        chk($sformatf("C_fetch%0d", i), i < fetch_log.size() ? fetch_log[i] : 32'hFFFF_FFFF, want[i]);
    end
    chk("C_beq_nt_lat", lat_log.size() > 1 ? lat_log[1] : 0, 3);
    chk("C_j_lat", lat_log.size() > 2 ? lat_log[2] : 0, 3);
    chk("C_beq_t_lat", lat_log.size() > 4 ? lat_log[4] : 0, 3);
    chk("C_retires", lat_log.size(), 7);

    // Program D: mul $5,$1,$2 with 7 and -6
    clear_mem();
    put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd7));
    put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFA));
    put(32'h08, enc_r(6'h18, 5'd1, 5'd2, 5'd5));
    put(32'h0C, enc_i(6'h2B, 5'd0, 5'd5, 16'h0080));
    put(32'h10, 32'hFC00_0000);
    put(32'h80, 32'h1234_5678);
    start_prog(0);
    wait_halt(500);
`ifdef MC_CPU_MUL_EN
    chk("D_mul", ram[32], 32'hFFFF_FFD6);
    chk("D_mul_lat", lat_log.size() > 2 ? lat_log[2] : 0, 36);
`else
    chk("D_untouched", ram[32], 32'h1234_5678);
    chk("D_retires", lat_log.size(), 2);
`endif

    // Reset asserted mid-store with the bus waiting
    clear_mem();
    put(32'h00, enc_j(32'h40));
    put(32'h40, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h44, enc_i(6'h2B, 5'd0, 5'd1, 16'd8));
    put(32'h4C, 32'hFC00_0000);
    start_prog(3);
    begin
      int n;
      for (n = 0; n < 200 && !(bus.mem_req_o && bus.mem_we_o); n++) @(negedge clk);
      chk("R_store_seen", {31'd0, bus.mem_req_o && bus.mem_we_o}, 32'd1);
    end
    rst_i = 1'b0;
    #1;
    chk("R_req_drop", {31'd0, bus.mem_req_o}, 32'd0);
    chk("R_we_drop", {31'd0, bus.mem_we_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("R_no_write", ram[2], 32'd0);
    chk("R_r1_clear", dut.rf[1], 32'd0);
    chk("R_pc", pc_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
